// File: rtl/mem_burst_ctrl.sv
// Burst front-end for an 8x32 register-file memory: one read or write burst of
// 1..8 beats at a time, addresses wrapping modulo the memory depth.
module mem_burst_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
    logic [ADDR_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_last_reg, rsp_last_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;

    // The response slot can take a new beat when empty or being emptied now.
    logic rsp_load;
    assign rsp_load = (state_reg == ST_READ) && (!rsp_valid_reg || rsp_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cur_addr_reg  <= '0;
            beat_cnt_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cur_addr_reg  <= cur_addr_next;
            beat_cnt_reg  <= beat_cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_last_reg  <= rsp_last_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_addr_next  = cur_addr_reg;
        beat_cnt_next  = beat_cnt_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_last_next  = rsp_last_reg;
        rsp_data_next  = rsp_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_next = cmd_addr;
                    beat_cnt_next = cmd_len;
                    state_next    = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_valid) begin
                    cur_addr_next = cur_addr_reg + 1'b1;
                    beat_cnt_next = beat_cnt_reg - 1'b1;
                    if (beat_cnt_reg == '0) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (rsp_load) begin
                    rsp_data_next  = mem_rdata;
                    rsp_valid_next = 1'b1;
                    rsp_last_next  = (beat_cnt_reg == '0);
                    cur_addr_next  = cur_addr_reg + 1'b1;
                    beat_cnt_next  = beat_cnt_reg - 1'b1;
                    if (beat_cnt_reg == '0) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_last_next  = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_reg == ST_IDLE);
        wr_ready  = (state_reg == ST_WRITE);
        mem_we    = (state_reg == ST_WRITE) && wr_valid;
        mem_addr  = cur_addr_reg;
        mem_wdata = wr_data;
        busy      = (state_reg != ST_IDLE);
        rsp_valid = rsp_valid_reg;
        rsp_last  = rsp_last_reg;
        rsp_data  = rsp_data_reg;
    end

endmodule
